// File: rtl/rpm_pkg.sv
// rpm_pkg: shared constants and helpers for the multi-channel RPM meter.
//   CNT_W_DEF / RPM_W_DEF / SCALE_DEF : default widths and count->RPM multiplier
//   WIN_W                             : window counter width for the default window
//   sat_mul(raw, scale[, w])          : raw*scale at full width, clamped to 2^w-1
package rpm_pkg;
  localparam int CNT_W_DEF         = 16;
  localparam int RPM_W_DEF         = 32;
  localparam int SCALE_DEF         = 5;
  localparam int WINDOW_CYCLES_DEF = 100000000;
  localparam int WIN_W             = $clog2(WINDOW_CYCLES_DEF);

  // Product is formed in 96 bits so it can never wrap before the clamp.
  // w is the output word width (1..64); the result is zero-extended to 64 bits.
  function automatic logic [63:0] sat_mul(input logic [63:0] raw,
                                          input logic [31:0] scale,
                                          input int unsigned w = RPM_W_DEF);
    logic [95:0] p;
    logic [63:0] lim;
    p   = {32'd0, raw} * {64'd0, scale};
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (p > {32'd0, lim}) ? lim : p[63:0];
  endfunction
endpackage

// File: rtl/rpm_meter_multi_if.sv
// rpm_meter_multi_if: control, sensor and result signals of the RPM meter.
//   enable     : 1 = measure, 0 = hold window idle
//   edge_mode  : 0 = rising edges, 1 = both edges
//   sa_input   : raw async sensor pulses, one bit per channel
//   rpm_output : scaled counts, channel i at [i*RPM_W +: RPM_W]
//   rpm_valid  : one-cycle strobe when rpm_output updates
//   overflow   : per channel, raw counter saturated in last window
//   stalled    : per channel, no pulses in last window
// master = pin/register-file side, slave = meter.
interface rpm_meter_multi_if #(
  parameter int NUM_CH = 2,
  parameter int RPM_W  = rpm_pkg::RPM_W_DEF
);
  logic                    enable;
  logic                    edge_mode;
  logic [NUM_CH-1:0]       sa_input;
  logic [NUM_CH*RPM_W-1:0] rpm_output;
  logic                    rpm_valid;
  logic [NUM_CH-1:0]       overflow;
  logic [NUM_CH-1:0]       stalled;

  modport master (output enable, edge_mode, sa_input,
                  input  rpm_output, rpm_valid, overflow, stalled);
  modport slave  (input  enable, edge_mode, sa_input,
                  output rpm_output, rpm_valid, overflow, stalled);
endinterface

// File: rtl/rpm_meter_multi_channel.sv
// rpm_channel: one pulse channel of the RPM meter.
//   clock, reset : system clock, async active-high reset
//   enable       : 0 clears the raw counter and ovf bit
//   edge_mode    : 0 = rising only, 1 = rising and falling
//   tc           : window terminal cycle (already qualified by enable)
//   sa           : raw async sensor input
//   rpm          : latched scaled count
//   ovf_flag     : counter saturated during last window
//   stalled      : zero pulses in last window
module rpm_channel import rpm_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int RPM_W = RPM_W_DEF,
  parameter int SCALE = SCALE_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             edge_mode,
  input  logic             tc,
  input  logic             sa,
  output logic [RPM_W-1:0] rpm,
  output logic             ovf_flag,
  output logic             stalled
);
  logic             s1, s2, s_d;
  logic             hit;
  logic [CNT_W-1:0] raw;
  logic             ovf;

  // 2-flop synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      s_d <= 1'b0;
    end else begin
      s1  <= sa;
      s2  <= s1;
      s_d <= s2;
    end
  end

  assign hit = (s2 & ~s_d) | (edge_mode & ~s2 & s_d);

  // An edge in the tc cycle belongs to the new window: reload to 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      raw <= '0;
      ovf <= 1'b0;
    end else if (!enable) begin
      raw <= '0;
      ovf <= 1'b0;
    end else if (tc) begin
      raw <= hit ? CNT_W'(1) : '0;
      ovf <= 1'b0;
    end else if (hit) begin
      if (raw == '1) ovf <= 1'b1;
      else           raw <= raw + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rpm      <= '0;
      ovf_flag <= 1'b0;
      stalled  <= 1'b0;
    end else if (tc) begin
      rpm      <= RPM_W'(sat_mul(64'(raw), 32'(SCALE), RPM_W));
      ovf_flag <= ovf;
      stalled  <= (raw == '0);
    end
  end
endmodule

// File: rtl/rpm_meter_multi.sv
// rpm_meter_multi: NUM_CH pulse counters sharing one WINDOW_CYCLES gate window.
//   clock, reset : system clock, async active-high reset
//   bus          : rpm_meter_multi_if.slave (enable, edge_mode, sa_input in;
//                  rpm_output, rpm_valid, overflow, stalled out)
// Owns the window counter, tc generation and the valid strobe; per-channel
// work lives in rpm_channel.
module rpm_meter_multi import rpm_pkg::*; #(
  parameter int NUM_CH        = 2,
  parameter int WINDOW_CYCLES = WINDOW_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int SCALE         = SCALE_DEF,
  parameter int RPM_W         = RPM_W_DEF
) (
  input logic              clock,
  input logic              reset,
  rpm_meter_multi_if.slave bus
);
  localparam int             WCW  = $clog2(WINDOW_CYCLES);
  localparam logic [WCW-1:0] LAST = WCW'(WINDOW_CYCLES - 1);

  logic [WCW-1:0]                win_cnt;
  logic                          tc;
  logic                          valid_q;
  logic [NUM_CH-1:0][RPM_W-1:0]  rpm_arr;
  logic [NUM_CH-1:0]             ovf_arr;
  logic [NUM_CH-1:0]             stl_arr;

  // Gating with enable means a window closing as enable drops is discarded.
  assign tc = bus.enable && (win_cnt == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                   win_cnt <= '0;
    else if (!bus.enable || tc)  win_cnt <= '0;
    else                         win_cnt <= win_cnt + WCW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) valid_q <= 1'b0;
    else       valid_q <= tc;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    rpm_channel #(
      .CNT_W (CNT_W),
      .RPM_W (RPM_W),
      .SCALE (SCALE)
    ) u_ch (
      .clock     (clock),
      .reset     (reset),
      .enable    (bus.enable),
      .edge_mode (bus.edge_mode),
      .tc        (tc),
      .sa        (bus.sa_input[i]),
      .rpm       (rpm_arr[i]),
      .ovf_flag  (ovf_arr[i]),
      .stalled   (stl_arr[i])
    );
  end

  assign bus.rpm_output = rpm_arr;
  assign bus.rpm_valid  = valid_q;
  assign bus.overflow   = ovf_arr;
  assign bus.stalled    = stl_arr;
endmodule

// File: tb/tb_rpm_meter_multi.sv
// tb_rpm_meter_multi: directed bench for rpm_meter_multi.
// dut_a uses CNT_W=16, dut_b uses CNT_W=4; both see the same stimulus.
module tb_rpm_meter_multi;
  localparam int W = 1000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       edge_mode = 1'b0;
  logic [1:0] sa = 2'b00;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         last_v;
  int         en_c;
  int         nv;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  rpm_meter_multi_if #(.NUM_CH(2), .RPM_W(32)) bus_a ();
  rpm_meter_multi_if #(.NUM_CH(2), .RPM_W(32)) bus_b ();

  assign bus_a.enable    = enable;
  assign bus_a.edge_mode = edge_mode;
  assign bus_a.sa_input  = sa;
  assign bus_b.enable    = enable;
  assign bus_b.edge_mode = edge_mode;
  assign bus_b.sa_input  = sa;

  rpm_meter_multi #(.NUM_CH(2), .WINDOW_CYCLES(W), .CNT_W(16), .SCALE(5), .RPM_W(32))
    dut_a (.clock(clock), .reset(reset), .bus(bus_a));
  rpm_meter_multi #(.NUM_CH(2), .WINDOW_CYCLES(W), .CNT_W(4), .SCALE(5), .RPM_W(32))
    dut_b (.clock(clock), .reset(reset), .bus(bus_b));

  typedef struct {
    bit       mode;
    int       n0, n1;
    int       a0, a1;
    bit [1:0] a_st, a_ov;
    int       b0;
    bit [1:0] b_ov;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) tick(1);
  endtask

  // Pulses 4 cycles high / 4 low, concurrently on both channels.
  task automatic pulses(input int n0, input int n1);
    int m;
    m = (n0 > n1) ? n0 : n1;
    for (int i = 0; i < m; i++) begin
      sa = {(i < n1), (i < n0)};
      tick(4);
      sa = 2'b00;
      tick(4);
    end
  endtask

  task automatic wait_valid(input string nm);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < W + 100 && !ok; n++) begin
      @(posedge clock);
      #1;
      ok = bus_a.rpm_valid;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: rpm_valid missing after %0d cycles, expected strobe", nm, W + 100);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b0, 10, 0,  50,  0, 2'b10, 2'b00, 50, 2'b00};
    vt[1] = '{1'b1, 10, 0, 100,  0, 2'b10, 2'b00, 75, 2'b01};
    vt[2] = '{1'b0, 20, 0, 100,  0, 2'b10, 2'b00, 75, 2'b01};
    vt[3] = '{1'b0,  3, 0,  15,  0, 2'b10, 2'b00, 15, 2'b00};
    vt[4] = '{1'b0,  2, 7,  10, 35, 2'b00, 2'b00, 10, 2'b00};
    vt[5] = '{1'b1,  0, 0,   0,  0, 2'b11, 2'b00,  0, 2'b00};

    // Reset state
    tick(3);
    chk("rst_out",   bus_a.rpm_output, 0);
    chk("rst_valid", bus_a.rpm_valid, 0);
    chk("rst_stall", bus_a.stalled, 0);
    chk("rst_ovf",   bus_a.overflow, 0);
    reset = 1'b0;
    tick(2);

    // First window after enable: full length, nothing counted
    enable = 1'b1;
    en_c = cyc;
    wait_valid("first_valid");
    chk("first_period", cyc - en_c, W);
    chk("first_ch0", bus_a.rpm_output[31:0], 0);
    chk("first_stall", bus_a.stalled, 2'b11);
    last_v = cyc;

    // Table-driven windows
    for (int k = 0; k < 6; k++) begin
      edge_mode = vt[k].mode;
      pulses(vt[k].n0, vt[k].n1);
      wait_valid($sformatf("v%0d_valid", k));
      chk($sformatf("v%0d_period", k), cyc - last_v, W);
      last_v = cyc;
      chk($sformatf("v%0d_a_ch0", k),  bus_a.rpm_output[31:0],  vt[k].a0);
      chk($sformatf("v%0d_a_ch1", k),  bus_a.rpm_output[63:32], vt[k].a1);
      chk($sformatf("v%0d_a_stall", k), bus_a.stalled,  vt[k].a_st);
      chk($sformatf("v%0d_a_ovf", k),   bus_a.overflow, vt[k].a_ov);
      chk($sformatf("v%0d_b_valid", k), bus_b.rpm_valid, 1);
      chk($sformatf("v%0d_b_ch0", k),  bus_b.rpm_output[31:0], vt[k].b0);
      chk($sformatf("v%0d_b_ovf", k),   bus_b.overflow, vt[k].b_ov);
      tick(1);
      chk($sformatf("v%0d_valid_drop", k), bus_a.rpm_valid, 0);
    end

    // Synchronised edge lands in the tc cycle: credited to the next window
    edge_mode = 1'b0;
    pulses(4, 0);
    wait_to(last_v + 997);
    sa = 2'b01;
    wait_valid("tc_valid");
    chk("tc_period", cyc - last_v, W);
    last_v = cyc;
    chk("tc_close_ch0", bus_a.rpm_output[31:0], 20);
    tick(3);
    sa = 2'b00;
    tick(4);
    pulses(2, 0);
    wait_valid("tc_next_valid");
    last_v = cyc;
    chk("tc_carry_ch0", bus_a.rpm_output[31:0], 15);

    // One-cycle reset in mid-window
    pulses(3, 0);
    wait_to(last_v + 500);
    reset = 1'b1;
    #1;
    chk("midrst_out",   bus_a.rpm_output[31:0], 0);
    chk("midrst_valid", bus_a.rpm_valid, 0);
    chk("midrst_stall", bus_a.stalled, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    en_c = cyc;
    pulses(2, 0);
    wait_valid("postrst_valid");
    chk("postrst_period", cyc - en_c, W);
    last_v = cyc;
    chk("postrst_ch0", bus_a.rpm_output[31:0], 10);

    // Enable dropped for 300 cycles mid-window
    pulses(3, 0);
    wait_to(last_v + 400);
    enable = 1'b0;
    nv = 0;
    repeat (300) begin
      tick(1);
      if (bus_a.rpm_valid) nv++;
    end
    chk("dis_strobes", nv, 0);
    chk("dis_hold_ch0", bus_a.rpm_output[31:0], 10);
    enable = 1'b1;
    en_c = cyc;
    pulses(4, 0);
    wait_valid("reen_valid");
    chk("reen_period", cyc - en_c, W);
    last_v = cyc;
    chk("reen_ch0", bus_a.rpm_output[31:0], 20);

    // Enable falls in the tc cycle: window discarded, no strobe
    wait_to(last_v + 999);
    enable = 1'b0;
    tick(1);
    chk("tcfall_valid", bus_a.rpm_valid, 0);
    chk("tcfall_hold", bus_a.rpm_output[31:0], 20);
    tick(2);
    enable = 1'b1;
    en_c = cyc;
    pulses(1, 0);
    wait_valid("tcfall_next_valid");
    chk("tcfall_period", cyc - en_c, W);
    chk("tcfall_ch0", bus_a.rpm_output[31:0], 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
